sl_rx_ctrl: RTL and testbench

SL_RX_CTRL -- requirements
Module: sl_rx_ctrl

---
 rtl/sl_rx_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_sl_rx_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sl_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sl_rx_ctrl
// Description : Host-side controller for a serial-link receiver. Buffers
//               completed received words in a small FIFO, exposes config,
//               data and status registers to a one-hot addressed host bus,
//               hands new configurations to the receiver through a
//               handshake FSM and raises level or pulse interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module sl_rx_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int CFG_TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rd_valid,
    output logic        irq,
    input  logic [15:0] rx_status_w,
    input  logic [31:0] rx_data_w,
    input  logic [15:0] rx_config_w,
    input  logic        rx_changed,
    output logic [15:0] rx_wr_config_w,
    output logic        rx_wr_enable
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = (CFG_TIMEOUT > 2) ? $clog2(CFG_TIMEOUT) : 1;

    localparam logic [3:0]    c_addr_config = 4'b0001;
    localparam logic [3:0]    c_addr_data_w = 4'b0010;
    localparam logic [3:0]    c_addr_data_r = 4'b0100;
    localparam logic [3:0]    c_addr_status = 4'b1000;
    localparam logic [CW-1:0] c_fifo_full   = CW'(FIFO_DEPTH);
    localparam logic [TW-1:0] c_tmo_last    = TW'(CFG_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CFG_WAIT  = 2'd1,
        ST_CFG_APPLY = 2'd2,
        ST_CFG_ERR   = 2'd3
    } cfg_state_t;

    cfg_state_t        r_state;
    cfg_state_t        w_state_nxt;
    logic [15:0]       r_pending;
    logic [TW-1:0]     r_tmo;
    logic              w_tmo_clr;
    logic              w_tmo_inc;

    logic [37:0]       r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;
    logic              r_udf;
    logic              r_cfg_err;
    logic              r_irq_pulse;

    logic              w_wr_cfg;
    logic              w_flush;
    logic              w_rd_acc;
    logic              w_rd_dr;
    logic              w_rd_st;
    logic              w_empty;
    logic              w_full;
    logic              w_cap;
    logic              w_push;
    logic              w_pop;
    logic              w_ovf_set;
    logic              w_udf_set;
    logic              w_cerr_set;
    logic [37:0]       w_head;
    logic [5:0]        w_head_st;
    logic [31:0]       w_head_data;
    logic [4:0]        w_count_ext;
    logic [31:0]       w_status_word;
    logic [31:0]       w_rd_value;
    logic              w_unused;

    // Host access decode; a write in the same cycle as a read suppresses the read
    assign w_wr_cfg = wr_en & (addr == c_addr_config);
    assign w_flush  = wr_en & (addr == c_addr_data_w);
    assign w_rd_acc = rd_en & ~wr_en;
    assign w_rd_dr  = w_rd_acc & (addr == c_addr_data_r);
    assign w_rd_st  = w_rd_acc & (addr == c_addr_status);

    // Only word-end or length-error events produce a buffered entry
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_fifo_full);
    assign w_cap     = rx_changed & (rx_status_w[3] | rx_status_w[5]);
    assign w_pop     = w_rd_dr & ~w_empty;
    // A flush discards anything arriving in the same cycle
    assign w_push    = w_cap & (~w_full | w_pop) & ~w_flush;
    assign w_ovf_set = w_cap & w_full & ~w_pop & ~w_flush;
    assign w_udf_set = w_rd_dr & w_empty;
    assign w_cerr_set = (r_state == ST_CFG_ERR);

    assign w_head      = r_mem[r_rd_ptr];
    assign w_head_st   = w_empty ? 6'd0 : w_head[37:32];
    assign w_head_data = w_empty ? 32'd0 : w_head[31:0];
    assign w_count_ext = 5'(r_count);

    assign w_status_word = {1'b0, w_head_st, r_cfg_err, (r_state != ST_IDLE),
                            r_udf, r_ovf, w_count_ext, rx_status_w};

    assign w_unused = &{1'b0, wdata[31:16]};

    // FIFO storage; contents are meaningless outside the pointer window
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {rx_status_w[5:0], rx_data_w};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky flags, cleared by a STATUS read unless set again in that cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf     <= 1'b0;
            r_udf     <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_ovf     <= w_ovf_set  | (r_ovf     & ~w_rd_st);
            r_udf     <= w_udf_set  | (r_udf     & ~w_rd_st);
            r_cfg_err <= w_cerr_set | (r_cfg_err & ~w_rd_st);
        end
    end

    // Read-data mux for the addressed register
    always_comb begin
        w_rd_value = 32'd0;
        case (addr)
            c_addr_config: w_rd_value = {16'd0, rx_config_w};
            c_addr_data_w: w_rd_value = 32'd0;
            c_addr_data_r: w_rd_value = w_head_data;
            c_addr_status: w_rd_value = w_status_word;
            default:       w_rd_value = 32'd0;
        endcase
    end

    // Registered read return; rdata is zero whenever rd_valid is low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata    <= 32'd0;
            rd_valid <= 1'b0;
        end else begin
            rdata    <= w_rd_acc ? w_rd_value : 32'd0;
            rd_valid <= w_rd_acc;
        end
    end

    // Config handshake state register, pending value and timeout counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pending <= 16'd0;
            r_tmo     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_wr_cfg) begin
                r_pending <= wdata[15:0];
            end
            if (w_tmo_clr) begin
                r_tmo <= '0;
            end else if (w_tmo_inc) begin
                r_tmo <= r_tmo + TW'(1);
            end
        end
    end

    // Config handshake next-state; a new CONFIG write restarts from CFG_WAIT
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_clr   = 1'b0;
        w_tmo_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_CFG_WAIT: begin
                if (!rx_status_w[1]) begin
                    w_state_nxt = ST_CFG_APPLY;
                    w_tmo_clr   = 1'b1;
                end
            end
            ST_CFG_APPLY: begin
                if (rx_config_w == r_pending) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo == c_tmo_last) begin
                    w_state_nxt = ST_CFG_ERR;
                end else begin
                    w_tmo_inc = 1'b1;
                end
            end
            ST_CFG_ERR: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (w_wr_cfg) begin
            w_state_nxt = ST_CFG_WAIT;
            w_tmo_clr   = 1'b1;
            w_tmo_inc   = 1'b0;
        end
    end

    assign rx_wr_enable   = (r_state == ST_CFG_APPLY);
    assign rx_wr_config_w = r_pending;

    // Pulse-mode interrupt source: one cycle after each push or cfg_err set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_pulse <= 1'b0;
        end else begin
            r_irq_pulse <= w_push | w_cerr_set;
        end
    end

    // IRQM selects pulse mode; otherwise irq is a level of pending conditions
    assign irq = rx_config_w[8] ? r_irq_pulse : (~w_empty | r_ovf | r_cfg_err);

endmodule
`default_nettype wire

// File: tb/tb_sl_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sl_rx_ctrl
// Description : Self-checking bench for sl_rx_ctrl: a table of per-cycle
//               vectors plus directed sequences for config handshake,
//               timeout, pulse interrupts and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sl_rx_ctrl;

    localparam logic [3:0] A_CFG = 4'b0001;
    localparam logic [3:0] A_DWR = 4'b0010;
    localparam logic [3:0] A_DR  = 4'b0100;
    localparam logic [3:0] A_ST  = 4'b1000;

    logic        clk;
    logic        rst_n;
    logic [3:0]  addr;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rd_valid;
    logic        irq;
    logic [15:0] rx_status_w;
    logic [31:0] rx_data_w;
    logic [15:0] rx_config_w;
    logic        rx_changed;
    logic [15:0] rx_wr_config_w;
    logic        rx_wr_enable;

    int n_checks = 0;
    int n_pass   = 0;

    sl_rx_ctrl #(.FIFO_DEPTH(4), .CFG_TIMEOUT(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .wr_en         (wr_en),
        .rd_en         (rd_en),
        .wdata         (wdata),
        .rdata         (rdata),
        .rd_valid      (rd_valid),
        .irq           (irq),
        .rx_status_w   (rx_status_w),
        .rx_data_w     (rx_data_w),
        .rx_config_w   (rx_config_w),
        .rx_changed    (rx_changed),
        .rx_wr_config_w(rx_wr_config_w),
        .rx_wr_enable  (rx_wr_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        rd;
        logic [3:0]  a;
        logic [31:0] wd;
        logic        chg;
        logic [15:0] st;
        logic [31:0] dat;
        logic [15:0] cfg;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic wr, input logic rd, input logic [3:0] a,
                               input logic [31:0] wd, input logic chg,
                               input logic [15:0] st, input logic [31:0] dat,
                               input logic [15:0] cfg, input logic e_rv,
                               input logic [31:0] e_rd, input logic e_irq);
        vec_t t;
        t.wr = wr; t.rd = rd; t.a = a; t.wd = wd; t.chg = chg; t.st = st;
        t.dat = dat; t.cfg = cfg; t.e_rv = e_rv; t.e_rd = e_rd; t.e_irq = e_irq;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rd_en = 1'b0; addr = 4'd0; wdata = 32'd0;
        rx_changed = 1'b0; rx_status_w = 16'd0; rx_data_w = 32'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        idle_inputs();
        rx_config_w = 16'd0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("reset_irq", {31'd0, irq}, 32'd0);
        chk("reset_wr_enable", {31'd0, rx_wr_enable}, 32'd0);
        chk("reset_wr_config", {16'd0, rx_wr_config_w}, 32'd0);
        rst_n = 1'b1;

        //          wr    rd    addr   wdata  chg   status    data          cfg       rv    rdata         irq
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b0, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0008, 32'hDEADBEEF, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h10010000, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_DR,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'hDEADBEEF, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b0, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, A_DR,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h00400000, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b1, 1'b1, A_ST,  32'd7, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b0, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, A_CFG, 32'd0, 1'b0, 16'h0000, 32'd0,        16'h00A5, 1'b1, 32'h000000A5, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, A_DWR, 32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0002, 32'h12345678, 16'h0000, 1'b0, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0008, 32'h11111111, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0020, 32'h22222222, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0008, 32'h33333333, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0028, 32'h44444444, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0008, 32'h55555555, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h10240000, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h10040000, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_DR,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h11111111, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_DR,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h22222222, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h10020000, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_DR,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h33333333, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h50010000, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_DR,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h44444444, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, A_DR,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0008, 32'hAAAA0000, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, A_DWR, 32'd9, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b0, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h00400000, 1'b0));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0008, 32'hAAAA0001, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0008, 32'hAAAA0002, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0008, 32'hAAAA0003, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b0, 4'd0,  32'd0, 1'b1, 16'h0008, 32'hAAAA0004, 16'h0000, 1'b0, 32'h00000000, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_DR,  32'd0, 1'b1, 16'h0008, 32'hAAAA0005, 16'h0000, 1'b1, 32'hAAAA0001, 1'b1));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0010, 32'd0,        16'h0000, 1'b1, 32'h10040010, 1'b1));
        tbl.push_back(v(1'b1, 1'b0, A_DWR, 32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b0, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, A_DR,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h00000000, 1'b0));
        tbl.push_back(v(1'b0, 1'b1, A_ST,  32'd0, 1'b0, 16'h0000, 32'd0,        16'h0000, 1'b1, 32'h00400000, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            wr_en = tbl[i].wr; rd_en = tbl[i].rd; addr = tbl[i].a; wdata = tbl[i].wd;
            rx_changed = tbl[i].chg; rx_status_w = tbl[i].st; rx_data_w = tbl[i].dat;
            rx_config_w = tbl[i].cfg;
            step();
            chk($sformatf("vec%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, tbl[i].e_rv});
            chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].e_rd);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, tbl[i].e_irq});
            chk($sformatf("vec%0d_wr_enable", i), {31'd0, rx_wr_enable}, 32'd0);
        end
        idle_inputs();
        rx_config_w = 16'd0;

        // Config held off while a word is in progress, applied once it ends
        rx_status_w = 16'h0002;
        wr_en = 1'b1; addr = A_CFG; wdata = 32'h0000_0110;
        step();
        wr_en = 1'b0; addr = 4'd0;
        chk("cfg_wait_we0", {31'd0, rx_wr_enable}, 32'd0);
        chk("cfg_wait_value", {16'd0, rx_wr_config_w}, 32'h0000_0110);
        step();
        step();
        chk("cfg_wait_we2", {31'd0, rx_wr_enable}, 32'd0);
        rd_en = 1'b1; addr = A_ST;
        step();
        rd_en = 1'b0; addr = 4'd0;
        chk("cfg_wait_status", rdata, 32'h0080_0002);
        rx_status_w = 16'h0000;
        step();
        chk("cfg_apply_we0", {31'd0, rx_wr_enable}, 32'd1);
        step();
        step();
        chk("cfg_apply_we2", {31'd0, rx_wr_enable}, 32'd1);
        rx_config_w = 16'h0110;
        step();
        chk("cfg_done_we", {31'd0, rx_wr_enable}, 32'd0);
        rd_en = 1'b1; addr = A_ST;
        step();
        rd_en = 1'b0; addr = 4'd0;
        chk("cfg_done_status", rdata, 32'h0000_0000);
        chk("cfg_done_irq", {31'd0, irq}, 32'd0);
        rx_config_w = 16'h0000;

        // Config never adopted: exactly CFG_TIMEOUT cycles of write enable
        wr_en = 1'b1; addr = A_CFG; wdata = 32'h0000_0055;
        step();
        wr_en = 1'b0; addr = 4'd0;
        hi = 0;
        for (int k = 0; k < 100; k++) begin
            step();
            if (rx_wr_enable) hi++;
            else if (hi > 0) break;
        end
        chk("tmo_we_cycles", hi, 32);
        step();
        chk("tmo_irq", {31'd0, irq}, 32'd1);
        rd_en = 1'b1; addr = A_ST;
        step();
        rd_en = 1'b0; addr = 4'd0;
        chk("tmo_status", rdata, 32'h0100_0000);
        chk("tmo_irq_cleared", {31'd0, irq}, 32'd0);

        // Pulse-mode interrupts for two pushes three cycles apart
        rx_config_w = 16'h0100;
        for (int k = 0; k < 8; k++) begin
            rx_changed  = (k == 0 || k == 4);
            rx_status_w = rx_changed ? 16'h0008 : 16'h0000;
            rx_data_w   = 32'(k);
            step();
            chk($sformatf("pulse_irq_c%0d", k), {31'd0, irq}, (k == 0 || k == 4) ? 32'd1 : 32'd0);
        end
        idle_inputs();
        wr_en = 1'b1; addr = A_DWR;
        step();
        wr_en = 1'b0; addr = 4'd0;
        rx_config_w = 16'h0000;
        step();
        chk("pulse_flushed_irq", {31'd0, irq}, 32'd0);

        // Asynchronous reset in the middle of CFG_APPLY and a read return
        rx_changed = 1'b1; rx_status_w = 16'h0020; rx_data_w = 32'hCAFEF00D;
        wr_en = 1'b1; addr = A_CFG; wdata = 32'h0000_0077;
        step();
        idle_inputs();
        rx_config_w = 16'h0033;
        rd_en = 1'b1; addr = A_CFG;
        step();
        rd_en = 1'b0; addr = 4'd0;
        chk("prerst_we", {31'd0, rx_wr_enable}, 32'd1);
        chk("prerst_rd_valid", {31'd0, rd_valid}, 32'd1);
        chk("prerst_rdata", rdata, 32'h0000_0033);
        chk("prerst_irq", {31'd0, irq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_we", {31'd0, rx_wr_enable}, 32'd0);
        chk("rst_async_rd_valid", {31'd0, rd_valid}, 32'd0);
        chk("rst_async_rdata", rdata, 32'd0);
        chk("rst_async_cfg", {16'd0, rx_wr_config_w}, 32'd0);
        chk("rst_async_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        rd_en = 1'b1; addr = A_ST;
        step();
        rd_en = 1'b0; addr = 4'd0;
        chk("postrst_status", rdata, 32'h0000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
